// File: rtl/lab5_pkg.sv
// Shared types and constants for the sequenced 3-tap weighted sum.
// Coefficients are signed 1.11 fixed point.
package lab5_pkg;

    localparam int DATA_W = 10;
    localparam int COEF_W = 12;
    localparam int FRAC_W = 11;
    localparam int ACC_W  = 24;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t K1 = 12'hC00;
    localparam coef_t K2 = 12'h500;
    localparam coef_t K3 = 12'hC00;

    typedef enum logic [2:0] {
        IDLE,
        MAC1,
        MAC2,
        MAC3,
        OUT
    } state_t;

    localparam logic [1:0] SEL_X1 = 2'd0;
    localparam logic [1:0] SEL_X2 = 2'd1;
    localparam logic [1:0] SEL_X3 = 2'd2;

`ifdef LAB5_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(2**(DATA_W-1));
`endif

    // Drop the fraction bits (floor) and fit the result into DATA_W.
    function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
`ifdef LAB5_SAT_EN
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_W;
        if (s > Y_MAX)
            return Y_MAX[DATA_W-1:0];
        else if (s < Y_MIN)
            return Y_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
`else
        return DATA_W'(a >>> FRAC_W);
`endif
    endfunction

endpackage

// File: rtl/lab5_mac.sv
// Shared multiply-accumulate: selects one tap and its coefficient,
// multiplies signed and accumulates with synchronous clear and enable.
module lab5_mac
    import lab5_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic [ACC_W-1:0]  sum
);

    logic [DATA_W-1:0]         x;
    coef_t                     k;
    logic signed [COEF_W-1:0]  xs;
    logic signed [2*COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc;

    always_comb begin
        x = x1;
        k = K1;
        case (sel)
            SEL_X1: begin x = x1; k = K1; end
            SEL_X2: begin x = x2; k = K2; end
            SEL_X3: begin x = x3; k = K3; end
            default: begin x = x1; k = K1; end
        endcase
    end

    assign xs   = {{(COEF_W-DATA_W){x[DATA_W-1]}}, x};
    assign prod = k * xs;
    assign term = ACC_W'(prod);
    assign sum  = acc + term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/lab5_fir_seq.sv
// Time-multiplexed 3-tap weighted sum with valid/ready on both sides.
// Define LAB5_SAT_EN to saturate y instead of wrapping it.
module lab5_fir_seq
    import lab5_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] x3;
    logic              load;
    logic              mac_clr;
    logic              mac_en;
    logic [1:0]        mac_sel;
    logic [ACC_W-1:0]  sum;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        mac_sel    = SEL_X1;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    mac_clr    = 1'b1;
                    state_next = MAC1;
                end
            end
            MAC1: begin
                mac_en     = 1'b1;
                mac_sel    = SEL_X1;
                state_next = MAC2;
            end
            MAC2: begin
                mac_en     = 1'b1;
                mac_sel    = SEL_X2;
                state_next = MAC3;
            end
            MAC3: begin
                mac_en     = 1'b1;
                mac_sel    = SEL_X3;
                state_next = OUT;
            end
            OUT: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
        end else if (load) begin
            x3 <= x2;
            x2 <= x1;
            x1 <= in_data;
        end
    end

    // The last term lands in the accumulator on this same edge, so take the
    // combinational sum rather than the registered accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            y <= '0;
        else if (state == MAC3)
            y <= reduce(sum);
    end

    lab5_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .sel   (mac_sel),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .sum   (sum)
    );

endmodule

// File: tb/tb_lab5_fir_seq.sv
// Directed bench for lab5_fir_seq: vector table plus handshake,
// stall, mid-operation reset and back-to-back streaming sequences.
module tb_lab5_fir_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] y;
    logic       out_valid;
    logic       out_ready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int din;
        int exp;
    } vec_t;

    vec_t vecs[8];

    lab5_fir_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input int x);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_data  = 10'(x);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok)
            @(posedge clk);
        #1 in_valid = 1'b0;
        if (!ok)
            check("send timeout", 0, 1);
    endtask

    task automatic recv(output int val);
        bit ok;
        ok  = 1'b0;
        val = 0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                val = $signed(y);
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok)
            @(posedge clk);
        #1 out_ready = 1'b0;
        if (!ok)
            check("recv timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit bad;
        int si;
        int oi;
        int last;
        int sdata[6];
        int sexp[6];

        vecs[0] = '{100, -50};
        vecs[1] = '{200, -38};
        vecs[2] = '{300, -75};
        vecs[3] = '{-512, 343};
`ifdef LAB5_SAT_EN
        vecs[4] = '{511, -512};
        vecs[5] = '{-512, 511};
        vecs[6] = '{0, -512};
`else
        vecs[4] = '{511, 298};
        vecs[5] = '{-512, -193};
        vecs[6] = '{0, 448};
`endif
        vecs[7] = '{1, 255};

        // reset state
        do_reset();
        @(negedge clk);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset y", $signed(y), 0);

        // vector table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din);
            recv(r);
            check($sformatf("vec%0d y", i), r, vecs[i].exp);
        end

        // acceptance-to-output timing
        do_reset();
        @(negedge clk);
        in_data  = 10'd100;
        in_valid = 1'b1;
        check("timing in_ready T", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        bad = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (out_valid || in_ready)
                bad = 1'b1;
        end
        check("timing T+1..T+3 quiet", int'(bad), 0);
        @(negedge clk);
        check("timing out_valid T+4", int'(out_valid), 1);
        check("timing in_ready T+4", int'(in_ready), 0);
        check("timing y", $signed(y), -50);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // stall in OUT with a pending sample
        do_reset();
        send(100);
        bad = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                bad = 1'b0;
                break;
            end
        end
        check("stall reach OUT", int'(bad), 0);
        in_data  = 10'd200;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || $signed(y) != -50 || in_ready)
                bad = 1'b1;
        end
        check("stall held stable", int'(bad), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall release out_valid", int'(out_valid), 0);
        check("stall release in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        recv(r);
        check("stall pending y", r, -38);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid)
                bad = 1'b1;
        end
        check("stall no duplicate", int'(bad), 0);

        // reset during MAC2
        do_reset();
        send(100);
        recv(r);
        send(200);
        recv(r);
        send(300);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort x1", int'(dut.x1), 0);
        check("abort x2", int'(dut.x2), 0);
        check("abort x3", int'(dut.x3), 0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid)
                bad = 1'b1;
        end
        check("abort no partial y", int'(bad), 0);
        send(100);
        recv(r);
        check("abort next y", r, -50);

        // continuous streaming
        do_reset();
        sdata = '{100, 200, 300, 0, 0, 0};
        sexp  = '{-50, -38, -75, 87, -150, 0};
        si = 0;
        oi = 0;
        last = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && oi < 6; cyc++) begin
            @(negedge clk);
            in_valid = (si < 6);
            in_data  = (si < 6) ? 10'(sdata[si]) : '0;
            if (out_valid) begin
                check($sformatf("stream y%0d", oi), $signed(y), sexp[oi]);
                if (oi > 0)
                    check($sformatf("stream gap%0d", oi), cyc - last, 5);
                last = cyc;
                oi++;
            end
            if (in_valid && in_ready)
                si++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream outputs", oi, 6);
        check("stream inputs", si, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
